// File: rtl/inst_buffer_pkg.sv
// Shared constants and entry layout for the instruction buffer.
// Optional macro IBUF_PRED_EN adds branch-prediction fields to every entry.
package inst_buffer_pkg;
  localparam int IBUF_DEPTH       = 16;
  localparam int IBUF_FULL_MARGIN = 4;
  localparam int ADDR_W           = 32;
`ifdef IBUF_PRED_EN
  localparam int ENTRY_W          = 97;
`else
  localparam int ENTRY_W          = 64;
`endif

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic FLUSH_ACTIVE = 1'b1;
  localparam logic STOP_ACTIVE  = 1'b1;

  typedef struct packed {
`ifdef IBUF_PRED_EN
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
`endif
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inst;
  } ibuf_entry_t;

  // Entries accepted in slot order when only `space` slots are free.
  function automatic logic [1:0] accept_cnt(input logic [1:0] nin, input int unsigned space);
    logic [1:0] acc;
    if (space >= 32'(nin)) begin
      acc = nin;
    end else begin
      acc = space[1:0];
    end
    return acc;
  endfunction
endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-response and decode-side signals of the instruction buffer.
// Optional macro IBUF_PRED_EN adds the prediction fields.
interface inst_buffer_if;
  import inst_buffer_pkg::*;

  logic              in_valid1;
  logic              in_valid2;
  logic [ADDR_W-1:0] in_pc;
  logic [ADDR_W-1:0] in_inst1;
  logic [ADDR_W-1:0] in_inst2;
  logic              deq1;
  logic              deq2;
  logic              out_valid1;
  logic              out_valid2;
  logic [ADDR_W-1:0] out_pc1;
  logic [ADDR_W-1:0] out_inst1;
  logic [ADDR_W-1:0] out_pc2;
  logic [ADDR_W-1:0] out_inst2;
`ifdef IBUF_PRED_EN
  logic              in_pred_taken;
  logic [ADDR_W-1:0] in_pred_target;
  logic              out_pred_taken1;
  logic              out_pred_taken2;
  logic [ADDR_W-1:0] out_pred_target1;
  logic [ADDR_W-1:0] out_pred_target2;
`endif

  modport master (
    output in_valid1, in_valid2, in_pc, in_inst1, in_inst2, deq1, deq2,
    input  out_valid1, out_valid2, out_pc1, out_inst1, out_pc2, out_inst2
`ifdef IBUF_PRED_EN
    , output in_pred_taken, in_pred_target,
    input  out_pred_taken1, out_pred_taken2, out_pred_target1, out_pred_target2
`endif
  );

  modport slave (
    input  in_valid1, in_valid2, in_pc, in_inst1, in_inst2, deq1, deq2,
    output out_valid1, out_valid2, out_pc1, out_inst1, out_pc2, out_inst2
`ifdef IBUF_PRED_EN
    , input in_pred_taken, in_pred_target,
    output out_pred_taken1, out_pred_taken2, out_pred_target1, out_pred_target2
`endif
  );
endinterface

// File: rtl/inst_buffer_ram.sv
// Entry storage: two write ports at tail/tail+1, two async read ports at head/head+1.
// Contents are not reset; validity is tracked by the pointer/count logic in the top.
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we1,
  input  logic             i_we2,
  input  logic [PTR_W-1:0] i_wptr,
  input  ibuf_entry_t      i_wdata1,
  input  ibuf_entry_t      i_wdata2,
  input  logic [PTR_W-1:0] i_rptr,
  output ibuf_entry_t      o_rdata1,
  output ibuf_entry_t      o_rdata2
);
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   w_wptr2;
  logic [PTR_W-1:0]   w_rptr2;

  assign w_wptr2 = i_wptr + PTR_W'(1);
  assign w_rptr2 = i_rptr + PTR_W'(1);

  // Dual write; the two addresses always differ since DEPTH >= 4.
  always_ff @(posedge clk) begin
    if (i_we1 == CHIP_ENABLE) begin
      r_mem[i_wptr] <= i_wdata1;
    end
    if (i_we2 == CHIP_ENABLE) begin
      r_mem[w_wptr2] <= i_wdata2;
    end
  end

  assign o_rdata1 = ibuf_entry_t'(r_mem[i_rptr]);
  assign o_rdata2 = ibuf_entry_t'(r_mem[w_rptr2]);
endmodule

// File: rtl/inst_buffer.sv
// Dual-issue instruction buffer: circular FIFO between icache response and decode.
// Optional macro IBUF_PRED_EN carries per-entry prediction info to decode.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH       = IBUF_DEPTH,
  parameter int FULL_MARGIN = IBUF_FULL_MARGIN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_id_stall,
  inst_buffer_if.slave bus,
  output logic         o_ibuffer_full,
  output logic         o_overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - FULL_MARGIN);

  logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt, w_space;
  logic             r_overflow_err;
  logic             w_flush, w_drop, w_we1, w_we2, w_valid1, w_valid2;
  logic [1:0]       w_nin, w_acc, w_nout;
  ibuf_entry_t      w_wdata1, w_wdata2, w_rdata1, w_rdata2;

  assign w_flush  = (i_flush == FLUSH_ACTIVE);
  assign w_valid1 = (r_count >= CNT_W'(1));
  assign w_valid2 = (r_count >= CNT_W'(2));
  // Space uses the pre-dequeue count: slots freed this cycle are not reused.
  assign w_space  = DEPTH_C - r_count;

  // Enqueue/dequeue sizing; a flush cycle writes nothing and reports no drop.
  always_comb begin
    w_nin = 2'd0;
    if (bus.in_valid1) begin
      if (bus.in_valid2) begin
        w_nin = 2'd2;
      end else begin
        w_nin = 2'd1;
      end
    end else begin
      w_nin = 2'd0;
    end
    w_acc  = accept_cnt(w_nin, 32'(w_space));
    w_we1  = !w_flush && (w_acc != 2'd0);
    w_we2  = !w_flush && (w_acc == 2'd2);
    w_drop = !w_flush && (w_acc != w_nin);
    w_nout = 2'd0;
    if (i_id_stall == STOP_ACTIVE) begin
      w_nout = 2'd0;
    end else if (bus.deq1 && w_valid1) begin
      if (bus.deq2 && w_valid2) begin
        w_nout = 2'd2;
      end else begin
        w_nout = 2'd1;
      end
    end else begin
      w_nout = 2'd0;
    end
  end

  // Pointer and occupancy update.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (w_flush) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      w_head_nxt  = r_head + PTR_W'(w_nout);
      w_tail_nxt  = r_tail + PTR_W'(w_acc);
      w_count_nxt = r_count + CNT_W'(w_acc) - CNT_W'(w_nout);
    end
  end

  // Entry formation; prediction belongs to the last valid slot only.
  always_comb begin
    w_wdata1      = '0;
    w_wdata2      = '0;
    w_wdata1.pc   = bus.in_pc;
    w_wdata1.inst = bus.in_inst1;
    w_wdata2.pc   = bus.in_pc + 32'd4;
    w_wdata2.inst = bus.in_inst2;
`ifdef IBUF_PRED_EN
    if (bus.in_valid2) begin
      w_wdata2.pred_taken  = bus.in_pred_taken;
      w_wdata2.pred_target = bus.in_pred_target;
    end else begin
      w_wdata1.pred_taken  = bus.in_pred_taken;
      w_wdata1.pred_target = bus.in_pred_target;
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      r_head         <= w_head_nxt;
      r_tail         <= w_tail_nxt;
      r_count        <= w_count_nxt;
      r_overflow_err <= w_drop;
    end
  end

  inst_buffer_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .i_we1    (w_we1),
    .i_we2    (w_we2),
    .i_wptr   (r_tail),
    .i_wdata1 (w_wdata1),
    .i_wdata2 (w_wdata2),
    .i_rptr   (r_head),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  assign bus.out_valid1 = w_valid1;
  assign bus.out_valid2 = w_valid2;
  assign bus.out_pc1    = w_rdata1.pc;
  assign bus.out_inst1  = w_rdata1.inst;
  assign bus.out_pc2    = w_rdata2.pc;
  assign bus.out_inst2  = w_rdata2.inst;
`ifdef IBUF_PRED_EN
  assign bus.out_pred_taken1  = w_rdata1.pred_taken;
  assign bus.out_pred_taken2  = w_rdata2.pred_taken;
  assign bus.out_pred_target1 = w_rdata1.pred_target;
  assign bus.out_pred_target2 = w_rdata2.pred_target;
`endif
  assign o_ibuffer_full = (r_count >= FULL_TH);
  assign o_overflow_err = r_overflow_err;
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH 16, FULL_MARGIN 4).
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic id_stall = 1'b0;
  logic full_s, ovf_s;
  int   checks = 0;
  int   errors = 0;

  inst_buffer_if bus();

  inst_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .i_id_stall     (id_stall),
    .bus            (bus),
    .o_ibuffer_full (full_s),
    .o_overflow_err (ovf_s)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic v2, input logic [31:0] pc,
                       input logic d1, input logic d2);
    bus.in_valid1 = v1;
    bus.in_valid2 = v2;
    bus.in_pc     = pc;
    bus.in_inst1  = pc ^ 32'hffff0000;
    bus.in_inst2  = (pc + 32'd4) ^ 32'hffff0000;
    bus.deq1      = d1;
    bus.deq2      = d2;
`ifdef IBUF_PRED_EN
    bus.in_pred_taken  = 1'b0;
    bus.in_pred_target = 32'h0;
`endif
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    flush    = 1'b0;
    id_stall = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #3;
    checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_v1 got %b exp 0", bus.out_valid1); end
    checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL rst_v2 got %b exp 0", bus.out_valid2); end
    checks++; if (full_s !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full_s); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf_s); end
    #4 rst_n = 1'b1;
    cyc();
    checks++; if (dut.r_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", dut.r_count); end
  endtask

  task automatic test_first_pair();
    drive(1'b1, 1'b1, 32'hbfc00000, 1'b0, 1'b0);
    bus.in_inst1 = 32'h24010001;
    bus.in_inst2 = 32'h24020002;
    cyc(); idle();
    checks++; if (bus.out_valid1 !== 1'b1) begin errors++; $display("FAIL pair_v1 got %b exp 1", bus.out_valid1); end
    checks++; if (bus.out_valid2 !== 1'b1) begin errors++; $display("FAIL pair_v2 got %b exp 1", bus.out_valid2); end
    checks++; if (bus.out_pc1 !== 32'hbfc00000) begin errors++; $display("FAIL pair_pc1 got %h exp bfc00000", bus.out_pc1); end
    checks++; if (bus.out_inst1 !== 32'h24010001) begin errors++; $display("FAIL pair_inst1 got %h exp 24010001", bus.out_inst1); end
    checks++; if (bus.out_pc2 !== 32'hbfc00004) begin errors++; $display("FAIL pair_pc2 got %h exp bfc00004", bus.out_pc2); end
    checks++; if (bus.out_inst2 !== 32'h24020002) begin errors++; $display("FAIL pair_inst2 got %h exp 24020002", bus.out_inst2); end
    checks++; if (dut.r_count !== 5'd2) begin errors++; $display("FAIL pair_count got %0d exp 2", dut.r_count); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(); idle();
    checks++; if (dut.r_count !== 5'd0) begin errors++; $display("FAIL pair_deq_count got %0d exp 0", dut.r_count); end
    checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL pair_deq_v1 got %b exp 0", bus.out_valid1); end
  endtask

  task automatic test_full_overflow();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 32'h1000 + 32'(k * 8), 1'b0, 1'b0);
      cyc(); idle();
      checks++; if (full_s !== (k == 5)) begin errors++; $display("FAIL fill_full k=%0d got %b exp %b", k, full_s, (k == 5)); end
    end
    checks++; if (dut.r_count !== 5'd12) begin errors++; $display("FAIL fill_count got %0d exp 12", dut.r_count); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(); idle();
    checks++; if (full_s !== 1'b0) begin errors++; $display("FAIL full_at11 got %b exp 0", full_s); end
    checks++; if (bus.out_pc1 !== 32'h1004) begin errors++; $display("FAIL deq1_pc1 got %h exp 1004", bus.out_pc1); end
    drive(1'b1, 1'b1, 32'h1030, 1'b0, 1'b0); cyc(); idle();
    drive(1'b1, 1'b1, 32'h1038, 1'b0, 1'b0); cyc(); idle();
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL ovf_at15 got %b exp 0", ovf_s); end
    drive(1'b1, 1'b1, 32'h1040, 1'b0, 1'b0); cyc(); idle();
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_partial got %b exp 1", ovf_s); end
    checks++; if (dut.r_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", dut.r_count); end
    cyc();
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %b exp 0", ovf_s); end
    drive(1'b1, 1'b1, 32'h1048, 1'b0, 1'b0); cyc(); idle();
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", ovf_s); end
    checks++; if (dut.r_count !== 5'd16) begin errors++; $display("FAIL ovf_hold got %0d exp 16", dut.r_count); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (bus.out_pc1 !== 32'h1004 + 32'(j * 8)) begin errors++; $display("FAIL drain_pc1 j=%0d got %h exp %h", j, bus.out_pc1, 32'h1004 + 32'(j * 8)); end
      checks++; if (bus.out_pc2 !== 32'h1008 + 32'(j * 8)) begin errors++; $display("FAIL drain_pc2 j=%0d got %h exp %h", j, bus.out_pc2, 32'h1008 + 32'(j * 8)); end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cyc(); idle();
    end
    checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", bus.out_valid1); end
  endtask

  task automatic test_simul_wrap();
    flush = 1'b1; cyc(); idle();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b1, 32'h2000 + 32'(k * 8), 1'b0, 1'b0);
      cyc(); idle();
    end
    drive(1'b1, 1'b0, 32'h2038, 1'b1, 1'b1); cyc(); idle();
    checks++; if (dut.r_count !== 5'd13) begin errors++; $display("FAIL sim_enq1_deq2 got %0d exp 13", dut.r_count); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cyc(); idle();
    end
    checks++; if (dut.r_count !== 5'd3) begin errors++; $display("FAIL sim_pre_count got %0d exp 3", dut.r_count); end
    checks++; if (dut.r_tail !== 4'd15) begin errors++; $display("FAIL sim_pre_tail got %0d exp 15", dut.r_tail); end
    drive(1'b1, 1'b1, 32'h203c, 1'b1, 1'b1); cyc(); idle();
    checks++; if (dut.r_count !== 5'd3) begin errors++; $display("FAIL sim_count got %0d exp 3", dut.r_count); end
    checks++; if (bus.out_pc1 !== 32'h2038) begin errors++; $display("FAIL sim_pc1 got %h exp 2038", bus.out_pc1); end
    checks++; if (bus.out_pc2 !== 32'h203c) begin errors++; $display("FAIL wrap_pc15 got %h exp 203c", bus.out_pc2); end
    checks++; if (bus.out_inst2 !== 32'hffff203c) begin errors++; $display("FAIL wrap_inst15 got %h exp ffff203c", bus.out_inst2); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); cyc(); idle();
    checks++; if (bus.out_pc1 !== 32'h2040) begin errors++; $display("FAIL wrap_pc0 got %h exp 2040", bus.out_pc1); end
    checks++; if (bus.out_inst1 !== 32'hffff2040) begin errors++; $display("FAIL wrap_inst0 got %h exp ffff2040", bus.out_inst1); end
    checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_v2 got %b exp 0", bus.out_valid2); end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 32'h3000, 1'b0, 1'b0); cyc(); idle();
    checks++; if (bus.out_pc2 !== 32'h3000) begin errors++; $display("FAIL stall_setup got %h exp 3000", bus.out_pc2); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); id_stall = 1'b1; cyc(); idle();
    checks++; if (dut.r_count !== 5'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", dut.r_count); end
    checks++; if (bus.out_pc1 !== 32'h2040) begin errors++; $display("FAIL stall_pc1 got %h exp 2040", bus.out_pc1); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); cyc(); idle();
    checks++; if (dut.r_count !== 5'd2) begin errors++; $display("FAIL deq2_only got %0d exp 2", dut.r_count); end
    drive(1'b0, 1'b1, 32'h4000, 1'b0, 1'b0); cyc(); idle();
    checks++; if (dut.r_count !== 5'd2) begin errors++; $display("FAIL slot2_only got %0d exp 2", dut.r_count); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); cyc(); idle();
    checks++; if (bus.out_pc1 !== 32'h3000) begin errors++; $display("FAIL unstall_pc1 got %h exp 3000", bus.out_pc1); end
  endtask

  task automatic test_flush();
    flush = 1'b1; cyc(); idle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h5000 + 32'(k * 8), 1'b0, 1'b0);
      cyc(); idle();
    end
    checks++; if (dut.r_count !== 5'd8) begin errors++; $display("FAIL flush_pre got %0d exp 8", dut.r_count); end
    drive(1'b1, 1'b1, 32'h6000, 1'b1, 1'b1); flush = 1'b1; cyc(); idle();
    checks++; if (dut.r_count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", dut.r_count); end
    checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL flush_v1 got %b exp 0", bus.out_valid1); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b exp 0", ovf_s); end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 32'h7000 + 32'(k * 8), 1'b0, 1'b0);
      cyc(); idle();
    end
    checks++; if (full_s !== 1'b1) begin errors++; $display("FAIL flush_full16 got %b exp 1", full_s); end
    drive(1'b1, 1'b1, 32'h7100, 1'b0, 1'b0); flush = 1'b1; cyc(); idle();
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL flush_full_ovf got %b exp 0", ovf_s); end
    checks++; if (full_s !== 1'b0) begin errors++; $display("FAIL flush_full_clr got %b exp 0", full_s); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 32'h8000, 1'b0, 1'b0); cyc(); idle();
    drive(1'b1, 1'b1, 32'h8008, 1'b0, 1'b0); cyc(); idle();
    drive(1'b1, 1'b0, 32'h8010, 1'b0, 1'b0); cyc(); idle();
    checks++; if (dut.r_count !== 5'd5) begin errors++; $display("FAIL arst_pre got %0d exp 5", dut.r_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL arst_v1 got %b exp 0", bus.out_valid1); end
    checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL arst_v2 got %b exp 0", bus.out_valid2); end
    checks++; if (dut.r_count !== 5'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", dut.r_count); end
    #2 rst_n = 1'b1;
    cyc();
    checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL arst_rel_v1 got %b exp 0", bus.out_valid1); end
    drive(1'b1, 1'b1, 32'hbfc00000, 1'b0, 1'b0); cyc(); idle();
    checks++; if (dut.r_head !== 4'd0) begin errors++; $display("FAIL arst_head got %0d exp 0", dut.r_head); end
    checks++; if (bus.out_pc1 !== 32'hbfc00000) begin errors++; $display("FAIL arst_pc1 got %h exp bfc00000", bus.out_pc1); end
    checks++; if (bus.out_pc2 !== 32'hbfc00004) begin errors++; $display("FAIL arst_pc2 got %h exp bfc00004", bus.out_pc2); end
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_full_overflow();
    test_simul_wrap();
    test_stall();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Consumer end of the fetch interface. Receives up to two instructions per cycle from the icache response path (the pc/pc+4 pair of one fetch) and queues them in a circular FIFO.
- Presents up to two oldest instructions to decode for dual issue.
- Drives ibuffer_full back to the PC stage so fetch requests are throttled.
- Cleared on pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- FULL_MARGIN, 4, free entries reserved for in-flight fetch responses; ibuffer_full asserts when count >= DEPTH - FULL_MARGIN.
- ADDR_W, 32, instruction/PC width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; empties buffer.
- id_stall  in  1  decode stalled; no dequeue this cycle.
- in_valid1  in  1  slot-1 response valid.
- in_valid2  in  1  slot-2 response valid.
- in_pc  in  32  PC of slot 1; slot 2 PC = in_pc + 4.
- in_inst1  in  32  slot-1 instruction.
- in_inst2  in  32  slot-2 instruction.
- deq1  in  1  decode consumes head entry.
- deq2  in  1  decode consumes head+1 entry.
- out_valid1  out  1  head entry present.
- out_valid2  out  1  head+1 entry present.
- out_pc1  out  32  head PC.
- out_inst1  out  32  head instruction.
- out_pc2  out  32  head+1 PC.
- out_inst2  out  32  head+1 instruction.
- ibuffer_full  out  1  throttle to PC stage.
- overflow_err  out  1  one-cycle pulse; an incoming entry was dropped.

Behaviour:
- State: entry RAM of {pc, inst}; head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (rst low, async): head = tail = count = 0; ibuffer_full = 0; overflow_err = 0; out_valid1/2 = 0. Entry RAM is not cleared; out_pc/out_inst are don't-care while not valid.
- Outputs are combinational from registered state (zero-latency read of head).
  - out_valid1 = count >= 1.
  - out_valid2 = count >= 2.
  - ibuffer_full = count >= DEPTH - FULL_MARGIN.
- Enqueue count nin:
  - 0 if in_valid1 = 0; in_valid2 without in_valid1 is ignored.
  - 1 if in_valid1 only.
  - 2 if both valid.
- Slot 1 is always written at tail, slot 2 at tail+1 (mod DEPTH).
- Accepted entries = min(nin, DEPTH - count), accepted in slot order. If any entry is dropped, overflow_err pulses the next cycle.
- Dequeue count nout:
  - 0 if id_stall = 1.
  - Otherwise deq1 & out_valid1 gives 1; additionally deq2 & out_valid2 gives 2.
  - deq2 without deq1 is ignored.
- Simultaneous enqueue and dequeue in the same cycle: count_next = count + accepted - nout. Space is computed from pre-dequeue count (freed slots are not reused the same cycle).
- flush = 1: next cycle head = tail = count = 0. Flush overrides all same-cycle enqueue/dequeue; responses arriving in the flush cycle are discarded and do not raise overflow_err.
- Fetch pair 0xbfc00000/0xbfc00004 lands at entries 0/1 after reset; the buffer never reorders entries.
- Wrap-around: tail = DEPTH-1 with nin = 2 writes entries DEPTH-1 and 0.

Optional Feature:
- Macro: IBUF_PRED_EN.
- When defined:
  - Extra inputs in_pred_taken (1) and in_pred_target (32), applying to the last valid slot of the fetch.
  - Each entry stores pred_taken and pred_target; the non-last slot stores 0.
  - Extra outputs out_pred_taken1/2 and out_pred_target1/2, aligned with out_pc1/2.
- When undefined: ports and storage are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file holds:
  - IBUF_DEPTH default.
  - IBUF_FULL_MARGIN default.
  - Entry-width constant (64, or 97 with IBUF_PRED_EN).
  - Existing ChipEnable/Flush/Stop polarity defines, reused.
- One sub-module, inst_buffer_ram: DEPTH-entry register array with 2 write ports at tail/tail+1 and 2 async read ports at head/head+1. Pointer/count control stays in the top.

Test Plan:
- Reset then enqueue pair in_pc = 0xbfc00000, inst 0x24010001/0x24020002 -> next cycle out_valid1/2 = 1, out_pc2 = 0xbfc00004, count = 2.
- Enqueue pairs with deq1 = deq2 = 0 until count = 12 -> ibuffer_full = 1 at count 12, = 0 at count 11; a 16th+ entry sets overflow_err for one cycle and count holds 16.
- With count = 3, enqueue 2 and dequeue 2 in the same cycle -> count = 3; order preserved across wrap at tail = 15 -> 0.
- id_stall = 1 with deq1 = deq2 = 1 -> no dequeue; deq2 = 1 with deq1 = 0 -> no dequeue.
- count = 8, flush = 1 together with in_valid1/2 = 1 -> next cycle count = 0, out_valid1 = 0, no overflow_err.
- Assert rst low mid-operation at count = 5 -> outputs 0 immediately (async), buffer empty after release.
